// File: rtl/ensemble_pkg.sv
// Shared constants and vote-result type for the ensemble result combiner.
// Bit positions describe the layout of the combined output beat.
package ensemble_pkg;

   localparam int LABEL_WIDTH_DEF = 8;
   localparam int LABEL_MAX       = 16;

   localparam int AGREE_LSB  = 16;
   localparam int TIE_BIT    = 18;
   localparam int LASTMM_BIT = 19;

   // label is sized for the widest supported label; narrower labels are zero-extended
   typedef struct packed {
      logic [LABEL_MAX-1:0] label;
      logic [1:0]           agree;
      logic                 tie;
   } vote_t;

endpackage

// File: rtl/ensemble_majority_vote.sv
// Combinational 2-of-3 majority vote over three class labels.
// A three-way disagreement falls back to the label of classifier TIE_SEL.
module ensemble_majority_vote
   import ensemble_pkg::*;
#(
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
   parameter int TIE_SEL     = 0
) (
   input  logic [LABEL_WIDTH-1:0] label_1,
   input  logic [LABEL_WIDTH-1:0] label_2,
   input  logic [LABEL_WIDTH-1:0] label_3,
   output vote_t                  vote
);

   logic                   eq_12;
   logic                   eq_13;
   logic                   eq_23;
   logic [LABEL_WIDTH-1:0] tie_label;

   assign eq_12 = (label_1 == label_2);
   assign eq_13 = (label_1 == label_3);
   assign eq_23 = (label_2 == label_3);

   assign tie_label = (TIE_SEL == 2) ? label_3 :
                      (TIE_SEL == 1) ? label_2 : label_1;

   // NOTE: every field gets a default before the branches so no latch is inferred.
   always_comb begin
      vote = '0;
      if (eq_12 && eq_13) begin
         vote.label[LABEL_WIDTH-1:0] = label_1;
         vote.agree                  = 2'd3;
      end else if (eq_12 || eq_13) begin
         vote.label[LABEL_WIDTH-1:0] = label_1;
         vote.agree                  = 2'd2;
      end else if (eq_23) begin
         vote.label[LABEL_WIDTH-1:0] = label_2;
         vote.agree                  = 2'd2;
      end else begin
         vote.label[LABEL_WIDTH-1:0] = tie_label;
         vote.agree                  = 2'd1;
         vote.tie                    = 1'b1;
      end
   end

endmodule

// File: rtl/ensemble_vote_combiner.sv
// Aligns three classifier result streams beat-by-beat, majority-votes the label
// and emits one combined AXI-Stream beat per triple plus running statistics.
module ensemble_vote_combiner
   import ensemble_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int KEEP_WIDTH  = 4,
   parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
   parameter int TIE_SEL     = 0,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
   input  logic                  s_axis_tvalid_1,
   input  logic                  s_axis_tvalid_2,
   input  logic                  s_axis_tvalid_3,
   output logic                  s_axis_tready_1,
   output logic                  s_axis_tready_2,
   output logic                  s_axis_tready_3,
   input  logic                  s_axis_tlast_1,
   input  logic                  s_axis_tlast_2,
   input  logic                  s_axis_tlast_3,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [CNT_WIDTH-1:0]  result_count,
   output logic [CNT_WIDTH-1:0]  tie_count,
   output logic [CNT_WIDTH-1:0]  last_mismatch_count
);

   logic [2:0]             s_valid;
   logic [2:0]             s_ready;
   logic [2:0]             s_last;
   logic [LABEL_WIDTH-1:0] s_label [3];

   logic [2:0]             full_q;
   logic [2:0]             last_q;
   logic [LABEL_WIDTH-1:0] label_q [3];

   logic                   fire;
   logic                   last_mismatch;
   vote_t                  vote;
   logic [DATA_WIDTH-1:0]  out_data;

   assign s_valid    = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
   assign s_last     = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};
   assign s_label[0] = s_axis_tdata_1[LABEL_WIDTH-1:0];
   assign s_label[1] = s_axis_tdata_2[LABEL_WIDTH-1:0];
   assign s_label[2] = s_axis_tdata_3[LABEL_WIDTH-1:0];

   // A complete triple moves on when the output register is empty or draining this cycle.
   assign fire    = (&full_q) && (!m_axis_tvalid || m_axis_tready);
   assign s_ready = ~full_q | {3{fire}};

   assign s_axis_tready_1 = s_ready[0];
   assign s_axis_tready_2 = s_ready[1];
   assign s_axis_tready_3 = s_ready[2];

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s_valid[i] && s_ready[i]) begin
               full_q[i] <= 1'b1;
            end else if (fire) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   // NOTE: payload registers have no reset; full_q alone says whether they hold a beat.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (s_valid[i] && s_ready[i]) begin
            label_q[i] <= s_label[i];
            last_q[i]  <= s_last[i];
         end
      end
   end

   ensemble_majority_vote #(
      .LABEL_WIDTH (LABEL_WIDTH),
      .TIE_SEL     (TIE_SEL)
   ) u_vote (
      .label_1 (label_q[0]),
      .label_2 (label_q[1]),
      .label_3 (label_q[2]),
      .vote    (vote)
   );

   assign last_mismatch = (|last_q) && !(&last_q);

   always_comb begin
      out_data                          = '0;
      out_data[LABEL_WIDTH-1:0]         = vote.label[LABEL_WIDTH-1:0];
      out_data[AGREE_LSB +: 2]          = vote.agree;
      out_data[TIE_BIT]                 = vote.tie;
      out_data[LASTMM_BIT]              = last_mismatch;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (fire) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= out_data;
         m_axis_tlast  <= |last_q;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   assign m_axis_tkeep = {KEEP_WIDTH{m_axis_tvalid}};

   // Statistics follow the flags carried in the beat actually handed downstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_count        <= '0;
         tie_count           <= '0;
         last_mismatch_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready) begin
         result_count        <= result_count + CNT_WIDTH'(1);
         tie_count           <= tie_count + CNT_WIDTH'(m_axis_tdata[TIE_BIT]);
         last_mismatch_count <= last_mismatch_count + CNT_WIDTH'(m_axis_tdata[LASTMM_BIT]);
      end
   end

   // Keep and the non-label payload bits are deliberately dropped.
   logic unused_inputs;
   assign unused_inputs = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                            s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, vote.label};

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Directed bench for ensemble_vote_combiner: two instances (TIE_SEL 0 and 2) share
// stimulus; queue-fed stream drivers, an output monitor and hand-computed expectations.
module tb_ensemble_vote_combiner;

   typedef struct packed {
      logic       last;
      logic [7:0] label;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_tdata_1, s_tdata_2, s_tdata_3;
   logic [3:0]  s_tkeep;
   logic        s_tvalid_1, s_tvalid_2, s_tvalid_3;
   logic        s_tlast_1, s_tlast_2, s_tlast_3;
   logic        m_ready;

   logic        s_tready0_1, s_tready0_2, s_tready0_3;
   logic [31:0] m_tdata0;
   logic [3:0]  m_tkeep0;
   logic        m_tvalid0, m_tlast0;
   logic [31:0] result_count0, tie_count0, lastmm_count0;

   logic        s_tready2_1, s_tready2_2, s_tready2_3;
   logic [31:0] m_tdata2;
   logic [3:0]  m_tkeep2;
   logic        m_tvalid2, m_tlast2;
   logic [31:0] result_count2, tie_count2, lastmm_count2;

   beat_t       q1[$], q2[$], q3[$];
   logic [32:0] got0[$];
   logic [31:0] got2[$];
   int          gcyc[$];
   logic [2:0]  en;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ensemble_vote_combiner #(.TIE_SEL(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata_1(s_tdata_1), .s_axis_tdata_2(s_tdata_2), .s_axis_tdata_3(s_tdata_3),
      .s_axis_tkeep_1(s_tkeep), .s_axis_tkeep_2(s_tkeep), .s_axis_tkeep_3(s_tkeep),
      .s_axis_tvalid_1(s_tvalid_1), .s_axis_tvalid_2(s_tvalid_2), .s_axis_tvalid_3(s_tvalid_3),
      .s_axis_tready_1(s_tready0_1), .s_axis_tready_2(s_tready0_2), .s_axis_tready_3(s_tready0_3),
      .s_axis_tlast_1(s_tlast_1), .s_axis_tlast_2(s_tlast_2), .s_axis_tlast_3(s_tlast_3),
      .m_axis_tdata(m_tdata0), .m_axis_tkeep(m_tkeep0), .m_axis_tvalid(m_tvalid0),
      .m_axis_tready(m_ready), .m_axis_tlast(m_tlast0),
      .result_count(result_count0), .tie_count(tie_count0), .last_mismatch_count(lastmm_count0)
   );

   ensemble_vote_combiner #(.TIE_SEL(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata_1(s_tdata_1), .s_axis_tdata_2(s_tdata_2), .s_axis_tdata_3(s_tdata_3),
      .s_axis_tkeep_1(s_tkeep), .s_axis_tkeep_2(s_tkeep), .s_axis_tkeep_3(s_tkeep),
      .s_axis_tvalid_1(s_tvalid_1), .s_axis_tvalid_2(s_tvalid_2), .s_axis_tvalid_3(s_tvalid_3),
      .s_axis_tready_1(s_tready2_1), .s_axis_tready_2(s_tready2_2), .s_axis_tready_3(s_tready2_3),
      .s_axis_tlast_1(s_tlast_1), .s_axis_tlast_2(s_tlast_2), .s_axis_tlast_3(s_tlast_3),
      .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
      .m_axis_tready(m_ready), .m_axis_tlast(m_tlast2),
      .result_count(result_count2), .tie_count(tie_count2), .last_mismatch_count(lastmm_count2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push3(input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3,
                        input logic t1 = 1'b0, input logic t2 = 1'b0, input logic t3 = 1'b0);
      q1.push_back({t1, l1});
      q2.push_back({t2, l2});
      q3.push_back({t3, l3});
   endtask

   task automatic next_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] exp0, input logic [31:0] exp2,
                             input logic exp_last, output int at_cyc);
      int          n;
      logic [32:0] obs;
      n      = 0;
      at_cyc = -1;
      while (got0.size() == 0 && n < 40) begin
         next_neg();
         n++;
      end
      check({tag, "_avail"}, 64'(got0.size() > 0), 64'd1);
      if (got0.size() > 0) begin
         obs    = got0.pop_front();
         at_cyc = gcyc.pop_front();
         check({tag, "_data"}, 64'(obs[31:0]), 64'(exp0));
         check({tag, "_last"}, 64'(obs[32]), 64'(exp_last));
         check({tag, "_data_ts2"}, 64'(got2.pop_front()), 64'(exp2));
      end
   endtask

   // Stream drivers: present the queue head just after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (en[0] && q1.size() > 0) begin
         s_tvalid_1 = 1'b1; s_tlast_1 = q1[0].last; s_tdata_1 = {24'hA5C3E1, q1[0].label};
      end else begin
         s_tvalid_1 = 1'b0; s_tlast_1 = 1'b0; s_tdata_1 = '0;
      end
      if (en[1] && q2.size() > 0) begin
         s_tvalid_2 = 1'b1; s_tlast_2 = q2[0].last; s_tdata_2 = {24'h5A3C1E, q2[0].label};
      end else begin
         s_tvalid_2 = 1'b0; s_tlast_2 = 1'b0; s_tdata_2 = '0;
      end
      if (en[2] && q3.size() > 0) begin
         s_tvalid_3 = 1'b1; s_tlast_3 = q3[0].last; s_tdata_3 = {24'hFFFF00, q3[0].label};
      end else begin
         s_tvalid_3 = 1'b0; s_tlast_3 = 1'b0; s_tdata_3 = '0;
      end
   end

   // Handshakes seen at the falling edge complete on the next rising edge.
   initial forever begin
      @(negedge clk);
      if (s_tvalid_1 && s_tready0_1 && q1.size() > 0) void'(q1.pop_front());
      if (s_tvalid_2 && s_tready0_2 && q2.size() > 0) void'(q2.pop_front());
      if (s_tvalid_3 && s_tready0_3 && q3.size() > 0) void'(q3.pop_front());
      if (rst_n && m_tvalid0 && m_ready) begin
         got0.push_back({m_tlast0, m_tdata0});
         got2.push_back(m_tdata2);
         gcyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, c1, c2, c3;
      rst_n   = 1'b0;
      m_ready = 1'b1;
      en      = 3'b111;
      s_tkeep = 4'hF;
      s_tdata_1 = '0; s_tdata_2 = '0; s_tdata_3 = '0;
      s_tvalid_1 = 1'b0; s_tvalid_2 = 1'b0; s_tvalid_3 = 1'b0;
      s_tlast_1 = 1'b0; s_tlast_2 = 1'b0; s_tlast_3 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      next_neg();
      check("rst_mvalid", 64'({m_tvalid0, m_tkeep0, m_tlast0}), 64'd0);
      check("rst_mdata", 64'(m_tdata0), 64'd0);
      check("rst_counts", {result_count0, tie_count0 | lastmm_count0}, 64'd0);
      check("rst_ready", 64'({s_tready0_3, s_tready0_2, s_tready0_1}), 64'b111);

      // 5,5,5 with exact latency
      push3(8'd5, 8'd5, 8'd5);
      next_neg();
      check("t1_ready", 64'({s_tvalid_1, s_tready0_3, s_tready0_2, s_tready0_1}), 64'b1111);
      next_neg();
      check("t1_lat_lo", 64'(m_tvalid0), 64'd0);
      next_neg();
      check("t1_lat_hi", 64'({m_tvalid0, m_tkeep0}), 64'h1F);
      check("t1_data", 64'(m_tdata0), 64'h0003_0005);
      check("t1_last", 64'(m_tlast0), 64'd0);
      next_neg();
      check("t1_count", 64'({m_tvalid0, result_count0}), 64'd1);
      expect_out("t1", 32'h0003_0005, 32'h0003_0005, 1'b0, c0);

      // Two-of-three and three-way disagreement under both tie selections
      push3(8'd7, 8'd3, 8'd7);
      expect_out("pair", 32'h0002_0007, 32'h0002_0007, 1'b0, c0);
      push3(8'd1, 8'd2, 8'd4);
      expect_out("tie", 32'h0005_0001, 32'h0005_0004, 1'b0, c0);
      next_neg();
      check("tie_count", {tie_count0, tie_count2}, {32'd1, 32'd1});

      // Mismatched tlasts
      push3(8'd6, 8'd6, 8'd6, 1'b1, 1'b1, 1'b0);
      expect_out("lastmm", 32'h000B_0006, 32'h000B_0006, 1'b1, c0);
      next_neg();
      check("lastmm_count", 64'(lastmm_count0), 64'd1);

      // Stream 1 runs ahead; the others join four cycles later
      en = 3'b001;
      push3(8'd10, 8'd10, 8'd20);
      push3(8'd11, 8'd11, 8'd21);
      push3(8'd12, 8'd12, 8'd22);
      next_neg();
      next_neg();
      check("oos_stall", 64'({s_tvalid_1, s_tready0_1}), 64'b10);
      repeat (4) next_neg();
      check("oos_hold", 64'({s_tready0_1, m_tvalid0}), 64'd0);
      check("oos_q1", 64'(q1.size()), 64'd2);
      en = 3'b111;
      expect_out("oos0", 32'h0002_000A, 32'h0002_000A, 1'b0, c0);
      expect_out("oos1", 32'h0002_000B, 32'h0002_000B, 1'b0, c0);
      expect_out("oos2", 32'h0002_000C, 32'h0002_000C, 1'b0, c0);

      // Backpressure for ten cycles, then back-to-back drain
      @(posedge clk);
      #1 m_ready = 1'b0;
      next_neg();
      for (int i = 0; i < 4; i++) push3(8'(30 + i), 8'(30 + i), 8'(30 + i));
      repeat (4) next_neg();
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", 64'({m_tvalid0, m_tdata0}), {31'd0, 1'b1, 32'h0003_001E});
         next_neg();
      end
      check("bp_ready", 64'({s_tready0_3, s_tready0_2, s_tready0_1}), 64'd0);
      check("bp_qsize", 64'({8'(q1.size()), 8'(q2.size()), 8'(q3.size())}), 64'h02_0202);
      @(posedge clk);
      #1 m_ready = 1'b1;
      expect_out("bp0", 32'h0003_001E, 32'h0003_001E, 1'b0, c0);
      expect_out("bp1", 32'h0003_001F, 32'h0003_001F, 1'b0, c1);
      expect_out("bp2", 32'h0003_0020, 32'h0003_0020, 1'b0, c2);
      expect_out("bp3", 32'h0003_0021, 32'h0003_0021, 1'b0, c3);
      check("bp_rate", 64'({8'(c1 - c0), 8'(c2 - c1), 8'(c3 - c2)}), 64'h01_0101);
      next_neg();
      check("sum_counts", 64'({result_count0[15:0], tie_count0[15:0], lastmm_count0[15:0]}),
            64'h000B_0001_0001);

      // Reset with two buffers full and the output valid
      @(posedge clk);
      #1 m_ready = 1'b0;
      next_neg();
      q1.push_back({1'b0, 8'd40}); q1.push_back({1'b0, 8'd41});
      q2.push_back({1'b0, 8'd40}); q2.push_back({1'b0, 8'd41});
      q3.push_back({1'b0, 8'd40});
      repeat (6) next_neg();
      check("pre_rst", 64'({m_tvalid0, s_tready0_3, s_tready0_2, s_tready0_1, m_tdata0}),
            {28'd0, 4'b1100, 32'h0003_0028});
      en = 3'b000;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      next_neg();
      check("mrst_valid", 64'({m_tvalid0, m_tkeep0, m_tvalid2, m_tkeep2, m_tlast2}), 64'd0);
      check("mrst_cnt0", {result_count0, tie_count0 | lastmm_count0}, 64'd0);
      check("mrst_cnt2", {result_count2, tie_count2 | lastmm_count2}, 64'd0);
      check("mrst_ready", 64'({s_tready0_3, s_tready0_2, s_tready0_1,
                               s_tready2_3, s_tready2_2, s_tready2_1}), 64'b111111);
      check("mrst_noout", 64'(got0.size()), 64'd0);
      @(posedge clk);
      #1 m_ready = 1'b1;
      next_neg();
      en = 3'b111;
      push3(8'd9, 8'd9, 8'd9);
      expect_out("post_rst", 32'h0003_0009, 32'h0003_0009, 1'b0, c0);
      next_neg();
      check("post_rst_count", 64'(result_count0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
